// File: rtl/instr_fetch_unit.sv
// Pipelined instruction fetch stage: credit-limited request/response fetch into a prefetch FIFO,
// with redirect flush and draining of responses that were already in flight.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop;

    logic [31:0]           fifo_data [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0]         fifo_rd;
    logic [PW-1:0]         fifo_wr;

    // Addresses of requests still awaiting their in-order response.
    logic [ADDR_WIDTH-1:0] aq_addr [DEPTH];
    logic [PW-1:0]         aq_rd;
    logic [PW-1:0]         aq_wr;

    logic [CW:0]   in_use;
    logic          req_fire;
    logic          rsp_take;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] outstanding_nxt;

    // Buffered plus in-flight instructions may never exceed the FIFO size, so a push never overflows.
    assign in_use        = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid = rst && (state == ST_RUN) && !redirect_valid && (in_use < DEPTH_C);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is stale (e.g. issued before a reset) and is ignored.
    assign rsp_take  = mem_rsp_valid && (outstanding != '0);
    assign fifo_push = rsp_take && (state == ST_RUN) && !redirect_valid;

    assign instr_valid = (count != '0);
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr       = instr_valid ? fifo_data[fifo_rd] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[fifo_rd]   : '0;

    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);

    // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Every request still outstanding after this edge belongs to the old stream.
                fetch_pc <= redirect_pc;
                count    <= '0;
                fifo_rd  <= '0;
                fifo_wr  <= '0;
                aq_rd    <= '0;
                aq_wr    <= '0;
                drop     <= outstanding_nxt;
                state    <= (outstanding_nxt == '0) ? ST_RUN : ST_DRAIN;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 1'b1;
                    aq_wr    <= aq_wr + 1'b1;
                end
                if (fifo_push) begin
                    fifo_wr <= fifo_wr + 1'b1;
                    aq_rd   <= aq_rd + 1'b1;
                end
                if (fifo_pop) begin
                    fifo_rd <= fifo_rd + 1'b1;
                end
                count <= count + CW'(fifo_push) - CW'(fifo_pop);
                if ((state == ST_DRAIN) && rsp_take) begin
                    drop <= drop - 1'b1;
                    if (drop == CW'(1)) begin
                        state <= ST_RUN;
                    end
                end
            end
        end
    end

    // NOTE: storage arrays carry no reset; which entries are live is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_addr[aq_wr] <= fetch_pc;
        end
        if (fifo_push) begin
            fifo_data[fifo_wr] <= mem_rsp_data;
            fifo_pc[fifo_wr]   <= aq_addr[aq_rd];
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written redirect/reset sequences,
// and randomized traffic scored against a queue-based model of the expected instruction stream.
module tb_instr_fetch_unit;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid, instr_ready;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;

    logic          w_rst;
    logic          w_mem_req_valid, w_mem_req_ready;
    logic [AW-1:0] w_mem_req_addr;
    logic          w_mem_rsp_valid;
    logic [31:0]   w_mem_rsp_data;
    logic          w_redirect_valid;
    logic [AW-1:0] w_redirect_pc;
    logic          w_instr_valid, w_instr_ready;
    logic [31:0]   w_instr;
    logic [AW-1:0] w_instr_pc;

    instr_fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    instr_fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFE)) dut_w (
        .clk(clk), .rst(w_rst),
        .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready), .mem_req_addr(w_mem_req_addr),
        .mem_rsp_valid(w_mem_rsp_valid), .mem_rsp_data(w_mem_rsp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: in-order responses, each due a given number of cycles after its handshake.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];
    int    last_due = 0;
    int    mem_lat  = 1;

    // Stream model: addresses the core should see, in order, since the last reset/redirect.
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = 32'h0;
    int          arrived   = 0;
    int          stale     = 0;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic cycle(input bit rst_v, input bit rdy, input bit irdy, input bit rdv,
                         input logic [31:0] rpc);
        bit rsp_now, exp_rv, exp_iv;
        int d;
        rst            = rst_v;
        mem_req_ready  = rdy;
        instr_ready    = irdy;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        rsp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_rsp_valid  = rsp_now;
        mem_rsp_data   = rsp_now ? (pend[0].addr << 2) : 32'hDEAD_BEEF;
        #1;
        s_rv    = mem_req_valid;
        s_addr  = mem_req_addr;
        s_iv    = instr_valid;
        s_pc    = instr_pc;
        s_instr = instr;

        exp_rv = rst_v && !rdv && (stale == 0) && (exp_q.size() < DEPTH);
        exp_iv = (arrived > 0);
        check("sb_req_valid", 32'(s_rv), 32'(exp_rv));
        if (rst_v) begin
            check("sb_req_addr", s_addr, exp_fetch);
            check("sb_instr_valid", 32'(s_iv), 32'(exp_iv));
            if (exp_iv && s_iv) begin
                check("sb_instr_pc", s_pc, exp_q[0]);
                check("sb_instr", s_instr, exp_q[0] << 2);
            end
        end

        if (!rst_v) begin
            pend.delete();
            exp_q.delete();
            arrived   = 0;
            stale     = 0;
            exp_fetch = 32'h0;
            last_due  = cyc;
        end else begin
            if (exp_iv && irdy) begin
                void'(exp_q.pop_front());
                arrived--;
            end
            if (rsp_now) begin
                void'(pend.pop_front());
                if (stale > 0) stale--;
                else if (!rdv) arrived++;
            end
            if (s_rv && rdy) begin
                d = cyc + mem_lat;
                if (d <= last_due) d = last_due + 1;
                pend.push_back('{addr: s_addr, due: d});
                last_due = d;
            end
            if (rdv) begin
                stale     = pend.size();
                exp_q.delete();
                arrived   = 0;
                exp_fetch = rpc;
            end else if (exp_rv && rdy) begin
                exp_q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        mem_lat = 1;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic wait_instr(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            seen = s_iv;
        end
        check({name, "_seen"}, 32'(seen), 32'h1);
        if (seen) check({name, "_pc"}, s_pc, exp_pc);
    endtask

    typedef struct {
        bit          do_reset;
        bit          rdy;
        bit          irdy;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit rdy, bit irdy, bit rv, int a, bit iv, int pc);
        vec_t v;
        v.do_reset = r;    v.rdy = rdy;        v.irdy = irdy;
        v.exp_rv = rv;     v.exp_addr = 32'(a);
        v.exp_iv = iv;     v.exp_pc = 32'(pc);
        return v;
    endfunction

    logic        w_pend_v = 1'b0;
    logic [31:0] w_pend_a = 32'h0;

    task automatic w_cycle(input bit rst_v, input bit inject, input bit erv, input logic [31:0] ea,
                           input bit eiv, input logic [31:0] epc);
        w_rst            = rst_v;
        w_mem_req_ready  = 1'b1;
        w_instr_ready    = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;
        w_mem_rsp_valid  = w_pend_v || inject;
        w_mem_rsp_data   = w_pend_v ? (w_pend_a << 2) : 32'hDEAD_BEEF;
        #1;
        check("w_req_valid", 32'(w_mem_req_valid), 32'(erv));
        if (rst_v) begin
            check("w_req_addr", w_mem_req_addr, ea);
            check("w_instr_valid", 32'(w_instr_valid), 32'(eiv));
            check("w_instr_pc", w_instr_pc, eiv ? epc : 32'h0);
            check("w_instr", w_instr, eiv ? (epc << 2) : 32'h0);
        end
        w_pend_v = w_mem_req_valid && w_mem_req_ready;
        w_pend_a = w_mem_req_addr;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        w_rst = 1'b0; w_mem_req_ready = 1'b0; w_mem_rsp_valid = 1'b0; w_mem_rsp_data = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_instr_ready = 1'b0;

        // Streaming with zero-wait memory.
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 5, 1, 3));
        // Core stalled: exactly DEPTH requests, then resume in order.
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 3, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 5, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 6, 1, 3));
        vecs.push_back(mk(0, 1, 1, 1, 7, 1, 4));
        // Memory ready toggling.
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3, 1, 2));

        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) reset_dut();
            cycle(1'b1, vecs[i].rdy, vecs[i].irdy, 1'b0, 32'h0);
            check("tbl_req_valid", 32'(s_rv), 32'(vecs[i].exp_rv));
            check("tbl_req_addr", s_addr, vecs[i].exp_addr);
            check("tbl_instr_valid", 32'(s_iv), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                check("tbl_instr_pc", s_pc, vecs[i].exp_pc);
                check("tbl_instr", s_instr, vecs[i].exp_pc << 2);
            end
            if (vecs[i].do_reset) begin
                check("tbl_rst_instr", s_instr, 32'h0);
                check("tbl_rst_instr_pc", s_pc, 32'h0);
            end
        end

        // Redirect with two requests in flight: both responses drained, then fetch 0x100.
        reset_dut();
        mem_lat = 3;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        check("t4_redirect_rv", 32'(s_rv), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_drain1_rv", 32'(s_rv), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_drain2_rv", 32'(s_rv), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_resume_rv", 32'(s_rv), 32'h1);
        check("t4_resume_addr", s_addr, 32'h100);
        wait_instr("t4_first", 32'h100);

        // Redirect coinciding with a response and an instruction handshake.
        reset_dut();
        mem_lat = 2;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        check("t5_hs_valid", 32'(s_iv), 32'h1);
        check("t5_hs_pc", s_pc, 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t5_after_iv", 32'(s_iv), 32'h0);
        check("t5_drain_rv", 32'(s_rv), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t5_resume_rv", 32'(s_rv), 32'h1);
        check("t5_resume_addr", s_addr, 32'h200);
        wait_instr("t5_first", 32'h200);

        // Randomized traffic against the stream model.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            mem_lat = int'($urandom_range(1, 3));
            rpc = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFD : $urandom;
            cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, rpc);
        end

        // Address wrap from a high reset PC, reset mid-stream, stale response after reset.
        w_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        w_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        w_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
        w_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        w_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE);
        w_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF);
        w_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 32'h0000_0000);
        w_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        w_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
        w_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        w_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE);
        w_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
